// File: rtl/fifo_drain_vr_if.sv
// Read-side bundle for fifo_drain_vr: FIFO pop interface plus the downstream valid/ready stream.
// master = the drain block; slave = the FIFO and stream consumer side.
interface fifo_drain_vr_if #(
  parameter int WID = 32
);
  logic           fifo_empty;
  logic [WID-1:0] fifo_dout;
  logic           fifo_readout;
  logic           out_valid;
  logic           out_ready;
  logic [WID-1:0] out_data;
  logic           out_last;

  modport master (
    input  fifo_empty, fifo_dout, out_ready,
    output fifo_readout, out_valid, out_data, out_last
  );

  modport slave (
    output fifo_empty, fifo_dout, out_ready,
    input  fifo_readout, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fifo_drain_vr.sv
// FIFO drain into a 2-slot skid buffer, framed into BURST-beat packets on a valid/ready stream.
// Optional stall statistic counter enabled by defining FIFO_DRAIN_STALL_STATS_EN.
//
// state | meaning
// IDLE  | no pops; buffered beats still drain downstream
// RUN   | popping while enable=1
// CLOSE | enable dropped mid-packet; popping until the beat carrying last
module fifo_drain_vr #(
  parameter int WID   = 32,
  parameter int BURST = 4,
  parameter int CWID  = $clog2(BURST) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                softreset,
  input  logic                enable,
  fifo_drain_vr_if.master     bus,
  output logic                busy,
  output logic [15:0]         pop_count,
  output logic [15:0]         stall_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CLOSE = 2'd2
  } state_t;

  localparam logic [CWID-1:0] BEAT_MAX = CWID'(BURST - 1);
  localparam logic [CWID-1:0] BEAT_ONE = CWID'(1);

  state_t          state_q;
  state_t          state_d;
  logic [CWID-1:0] beat_cnt;
  logic [CWID-1:0] beat_cnt_d;
  logic [1:0]      occ;
  logic [1:0]      wr_idx;
  logic [WID-1:0]  data0;
  logic [WID-1:0]  data1;
  logic            last0;
  logic            last1;
  logic            clr;
  logic            pop;
  logic            xfer;
  logic            valid;
  logic            last_flag;

  assign clr       = rst | softreset;
  assign valid     = (occ != 2'd0);
  assign xfer      = valid & bus.out_ready;
  assign last_flag = (beat_cnt == BEAT_MAX);
  assign pop       = !clr && !bus.fifo_empty && (state_q != IDLE) &&
                     ((occ != 2'd2) || bus.out_ready);

  // Tail slot index after this cycle's shift-out.
  assign wr_idx = occ - 2'(xfer);

  assign bus.fifo_readout = pop;
  assign bus.out_valid    = valid;
  assign bus.out_data     = valid ? data0 : '0;
  assign bus.out_last     = valid ? last0 : 1'b0;
  assign busy             = (state_q != IDLE) || valid;

  always_comb begin
    beat_cnt_d = beat_cnt;
    if (pop) begin
      beat_cnt_d = last_flag ? '0 : beat_cnt + BEAT_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        // Judge packet completion on the post-pop count so a pop this cycle never leaves a packet open.
        if (!enable) state_d = (beat_cnt_d == '0) ? IDLE : CLOSE;
      end
      CLOSE: begin
        if (pop && last_flag) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      beat_cnt <= '0;
      occ      <= 2'd0;
      data0    <= '0;
      data1    <= '0;
      last0    <= 1'b0;
      last1    <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_cnt <= beat_cnt_d;
      occ      <= occ + 2'(pop) - 2'(xfer);
      if (xfer) begin
        data0 <= data1;
        last0 <= last1;
      end
      // Later assignment wins when the popped beat lands directly in the head slot.
      if (pop) begin
        if (wr_idx == 2'd0) begin
          data0 <= bus.fifo_dout;
          last0 <= last_flag;
        end else begin
          data1 <= bus.fifo_dout;
          last1 <= last_flag;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pop_count <= 16'h0;
    end else if (pop) begin
      pop_count <= pop_count + 16'h1;
    end
  end

`ifdef FIFO_DRAIN_STALL_STATS_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      stall_cnt <= 16'h0;
    end else if (valid && !bus.out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h1;
    end
  end
`else
  assign stall_cnt = 16'h0;
`endif

endmodule
